playseq_preview_sequencer: RTL and testbench

PLAYSEQ_PREVIEW_SEQUENCER -- requirements
Module: playseq_preview_sequencer

---
 rtl/playseq_pkg.sv | 22 ++
 rtl/playseq_timer_duracao.sv | 24 ++
 rtl/playseq_preview_sequencer.sv | 85 ++++++++
 tb/tb_playseq_preview_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/playseq_pkg.sv
// playseq_pkg: state codes, default durations and the duration helper shared by the preview sequencer
package playseq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SHOW = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } estado_t;

    localparam int T_ON_DEF  = 2000;
    localparam int T_OFF_DEF = 500;

    // Speed levels halve the base time; a zero result still costs one cycle.
    function automatic logic [15:0] duracao(input logic [15:0] base, input logic [1:0] nivel);
        logic [15:0] d;
        d = base >> nivel;
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/playseq_timer_duracao.sv
// playseq_timer_duracao: loadable down-counter that pulses fim on the last cycle of a loaded duration
module playseq_timer_duracao (
    input  logic        clock,
    input  logic        reset,
    input  logic        carga,
    input  logic [15:0] valor,
    output logic        fim
);

    logic [15:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (carga)
            cnt <= valor;
        else if (cnt != 16'd0)
            cnt <= cnt - 16'd1;
    end

    // A load of D makes fim fire on the D-th cycle after the load edge.
    assign fim = (cnt == 16'd1);

endmodule

// File: rtl/playseq_preview_sequencer.sv
// playseq_preview_sequencer: plays stored one-hot LED steps 0..limite with level-scaled on/off times
module playseq_preview_sequencer
    import playseq_pkg::*;
#(
    parameter int T_ON  = T_ON_DEF,
    parameter int T_OFF = T_OFF_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic [1:0] nivel,
    input  logic [3:0] limite,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done,
    output logic [2:0] db_estado
);

    estado_t     state;
    logic [1:0]  nivel_l;
    logic [3:0]  limite_l;
    logic        fim;
    logic        carga;
    logic [15:0] valor;

    // SHOW is timed from the LOAD exit, GAP from the SHOW exit; cancel clears the timer.
    assign carga = cancel | (state == LOAD) | ((state == SHOW) & fim);
    assign valor = cancel          ? 16'd0 :
                   (state == LOAD) ? duracao(16'(T_ON), nivel_l) :
                                     duracao(16'(T_OFF), nivel_l);

    playseq_timer_duracao u_timer (
        .clock (clock),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .fim   (fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            endereco <= '0;
            leds     <= '0;
            nivel_l  <= '0;
            limite_l <= '0;
        end else if (cancel) begin
            state    <= IDLE;
            endereco <= '0;
            leds     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    nivel_l  <= nivel;
                    limite_l <= limite;
                    endereco <= '0;
                    leds     <= '0;
                end
                LOAD: begin
                    leds  <= dado_mem;
                    state <= SHOW;
                end
                SHOW: if (fim) begin
                    leds  <= '0;
                    state <= (endereco == limite_l) ? DONE : GAP;
                end
                GAP: if (fim) begin
                    endereco <= endereco + 4'd1;
                    state    <= LOAD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign db_estado = state;

endmodule

// File: tb/tb_playseq_preview_sequencer.sv
// tb_playseq_preview_sequencer: scoreboard bench checking step patterns, on/gap lengths and preview totals
module tb_playseq_preview_sequencer;
    import playseq_pkg::*;

    localparam int TON  = 8;
    localparam int TOFF = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] nivel = '0;
    logic [3:0] limite = '0;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [2:0] db_estado;
    logic [3:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {logic [3:0] pat; int len; int gap;} show_t;
    typedef struct {int cycles; int dones; int done_at; int max_addr;} prev_t;
    show_t show_q[$];
    prev_t prev_q[$];

    always #5 clock = ~clock;

    assign dado_mem = mem[endereco];

    playseq_preview_sequencer #(.T_ON(TON), .T_OFF(TOFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cancel    (cancel),
        .nivel     (nivel),
        .limite    (limite),
        .dado_mem  (dado_mem),
        .endereco  (endereco),
        .leds      (leds),
        .busy      (busy),
        .done      (done),
        .db_estado (db_estado)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dur(input int base, input int n);
        int d;
        d = base >> n;
        return (d == 0) ? 1 : d;
    endfunction

    task automatic expect_preview(input int n, input int lim);
        int on, off, total;
        on    = dur(TON, n);
        off   = dur(TOFF, n);
        total = (lim + 1) * (1 + on) + lim * off + 1;
        for (int i = 0; i <= lim; i++)
            show_q.push_back('{pat: mem[i], len: on, gap: (i == 0) ? 1 : off + 1});
        prev_q.push_back('{cycles: total, dones: 1, done_at: total, max_addr: lim});
    endtask

    task automatic pulse_start(input int n, input int lim);
        @(posedge clock); #1;
        start  = 1'b1;
        nivel  = 2'(n);
        limite = 4'(lim);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        check("idle_timeout", int'(busy), 0);
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_leds"}, int'(leds), 0);
        check({tag, "_endereco"}, int'(endereco), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_estado"}, int'(db_estado), int'(IDLE));
    endtask

    // Monitor: turns the output stream into show records and per-preview totals.
    initial begin
        int bcnt = 0, dcnt = 0, dat = 0, maxa = 0, zcnt = 0, clen = 0;
        logic [3:0] cpat = '0;
        logic pbusy = 1'b0;
        show_t s;
        prev_t p;
        forever begin
            @(negedge clock);
            if (leds != 4'd0) begin
                if (clen == 0) cpat = leds;
                clen++;
            end else begin
                if (clen > 0) begin
                    if (show_q.size() == 0) check("show_unexpected", 1, 0);
                    else begin
                        s = show_q.pop_front();
                        check("show_pattern", int'(cpat), int'(s.pat));
                        check("show_len", clen, s.len);
                        check("gap_before", zcnt, s.gap);
                    end
                    clen = 0;
                    zcnt = 0;
                end
                if (busy) zcnt++;
            end
            if (busy) begin
                bcnt++;
                if (int'(endereco) > maxa) maxa = int'(endereco);
            end
            if (done) begin
                dcnt++;
                dat = bcnt;
            end
            if (pbusy && !busy) begin
                if (prev_q.size() == 0) check("preview_unexpected", 1, 0);
                else begin
                    p = prev_q.pop_front();
                    check("busy_cycles", bcnt, p.cycles);
                    check("done_pulses", dcnt, p.dones);
                    check("done_at", dat, p.done_at);
                    check("max_endereco", maxa, p.max_addr);
                end
                bcnt = 0; dcnt = 0; dat = 0; maxa = 0; zcnt = 0;
            end
            pbusy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
        #12;
        check_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // start together with cancel must not leave IDLE
        @(posedge clock); #1;
        start = 1'b1; cancel = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_busy", int'(busy), 0);
        check("start_cancel_estado", int'(db_estado), int'(IDLE));

        // nominal three-step preview
        expect_preview(0, 2);
        pulse_start(0, 2);
        check("t1_estado_load", int'(db_estado), int'(LOAD));
        @(posedge clock); #1;
        check("t1_estado_show", int'(db_estado), int'(SHOW));
        check("t1_leds_show", int'(leds), 1);
        repeat (8) @(posedge clock); #1;
        check("t1_estado_gap", int'(db_estado), int'(GAP));
        check("t1_leds_gap", int'(leds), 0);
        wait_idle();

        // fastest level, single step
        expect_preview(2, 0);
        pulse_start(2, 0);
        wait_idle();

        // cancel in the second cycle of the second SHOW
        show_q.push_back('{pat: 4'b0001, len: 8, gap: 1});
        show_q.push_back('{pat: 4'b0010, len: 2, gap: 5});
        prev_q.push_back('{cycles: 16, dones: 0, done_at: 0, max_addr: 1});
        pulse_start(0, 2);
        repeat (15) @(posedge clock); #1;
        cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0;
        check_zero("cancel");
        wait_idle();

        // start re-pulsed during GAP with other settings is ignored
        expect_preview(0, 2);
        pulse_start(0, 2);
        repeat (10) @(posedge clock); #1;
        start = 1'b1; nivel = 2'd3; limite = 4'd0;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle();

        // asynchronous reset in the middle of the first SHOW
        show_q.push_back('{pat: 4'b0001, len: 3, gap: 1});
        prev_q.push_back('{cycles: 4, dones: 0, done_at: 0, max_addr: 0});
        pulse_start(0, 2);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (3) @(posedge clock); #1;
        check("reset_stays_idle", int'(busy), 0);
        expect_preview(1, 2);
        pulse_start(1, 2);
        wait_idle();

        // sixteen steps at level 3 with a zero OFF time clamped to one cycle
        expect_preview(3, 15);
        pulse_start(3, 15);
        wait_idle();

        check("show_q_left", show_q.size(), 0);
        check("prev_q_left", prev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
